ball_horizontal_counter: RTL and testbench
==========================================

# ball_horizontal_counter

Ball horizontal position counter for Pong, directly downstream of the ball horizontal direction circuit. It is a free-running 9-bit pixel counter whose reload value is chosen from the direction code (`aa`, `ba`), so its period is 454, 455 or 456 clocks. Against the fixed 455-clock line, a 455-clock period holds the ball still, and 454 or 456 walks it left or right. It produces the ball's horizontal video window (`hball`) and a terminal-count strobe for the ball video mixer.

## Interface
Parameters:
- `BASE` — 9'd55 — reload base value. Reload is `BASE + {ba,aa}`.
- `WIDTH_PX` — 4 — ball width in clocks.

Ports:
- `clk7_159` in 1 — 7.159 MHz pixel clock. Single clock domain.
- `_rst` in 1 — asynchronous active-low reset.
- `aa` in 1 — direction code LSB, from the ball horizontal direction circuit.
- `ba` in 1 — direction code MSB, from the same circuit.
- `recentre` in 1 — synchronous active-high serve/miss recentre request.
- `hpos` out 9 — current counter value.
- `hball_tc` out 1 — one-clock strobe, asserted when `hpos` = 511.
- `hball` out 1 — ball horizontal video, high for `WIDTH_PX` clocks after `hball_tc`.

## Operation
- Counter: increments by 1 every `clk7_159` edge. It is unsigned 9-bit.
- Reload: in the cycle where `hpos` = 511, the next value is `BASE + {ba,aa}`, not 0. `aa` and `ba` are sampled only in that cycle.
- Period is `512 - (BASE + {ba,aa})`:
  - `{ba,aa}` = 2'b10 (move=0, stationary) → 455.
  - `{ba,aa}` = 2'b01 (moving right) → 456.
  - `{ba,aa}` = 2'b11 (moving left) → 454.
  - 2'b00 is not produced upstream. If it arrives anyway, the period is 457, with no special handling.
- `hball_tc`: combinational decode of `hpos` = 511. It is registered-clean because `hpos` is a register.
- Window FSM, two states:
  - IDLE → VID on `hball_tc`; the 2-bit window count loads 0.
  - VID: `hball`=1; the window count increments each clock.
  - VID → IDLE when the count = `WIDTH_PX-1`.
  - A `hball_tc` arriving while in VID restarts the window at count 0. Unreachable for periods ≥454; specified for robustness only.
- `recentre`: the next `hpos` is 9'd256 and the window FSM goes to IDLE.
  - `recentre` has priority over reload and over counting.
  - If `recentre` and `hpos`=511 coincide, `hball_tc` is still asserted that cycle, but the window does not start.

## Timing
- Reset values: `hpos`=0, `hball_tc`=0, `hball`=0, FSM=IDLE, window count=0.
- First `hball_tc` occurs 511 clocks after `_rst` deasserts.
- `hball` rises on the clock edge after the `hball_tc` cycle. It stays high exactly `WIDTH_PX` clocks, then falls.
- Latency `aa`/`ba` → effect: they are sampled at the `hpos`=511 edge, so a change affects only the following period.
- `recentre` → `hpos`=256 on the next edge. `hball` drops on the same edge.
- Asserting `_rst` mid-window clears `hball` immediately, asynchronously, without waiting for a clock edge.
- No combinational path from any input to any output.

## Structure
- Shared package `pong_pkg` holds:
  - `BALL_H_BASE` = 55.
  - `BALL_WIDTH_PX` = 4.
  - `HCNT_W` = 9.
  - `LINE_CLOCKS` = 455.
  - `HBALL_RECENTRE` = 9'd256.
- One sub-module, `ball_video_window`: the IDLE/VID FSM plus the 2-bit window count.
  - Inputs: `clk7_159`, `_rst`, `start`, `clr`.
  - Output: `hball`.
- The top-level module holds the counter, reload mux and `recentre` priority.

## Test plan
- **Reset, stationary:** release `_rst` with `aa`=0, `ba`=1 held → `hball_tc` at clock 511 after release, then every 455 clocks; `hball` high for 4 clocks starting one clock after each strobe.
- **Right:** hold `aa`=1, `ba`=0 → after the first reload, `hball_tc` spacing = 456; `hpos` after reload = 56.
- **Left:** hold `aa`=1, `ba`=1 → spacing = 454; reload value = 58.
- **Mid-period direction change:** switch `{ba,aa}` from 2'b10 to 2'b11 at `hpos`=300 → current period stays 455, next is 454. Toggle again at `hpos`=511 → the new value applies to that reload.
- **Recentre:** pulse `recentre` during `hball` high → next `hpos`=256, `hball`=0 on the same edge; next `hball_tc` 255 clocks later. Pulse `recentre` with `hpos`=511 → `hball_tc`=1 that cycle, `hball` stays 0, `hpos`=256.
- **Async reset mid-window:** drop `_rst` two clocks into `hball` → `hball`, `hpos`, `hball_tc` go to 0 before the next `clk7_159` edge; after release, the first strobe is again 511 clocks later.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong constants and types.
// Horizontal timing, ball geometry and window FSM states.
package pong_pkg;

  localparam int BALL_H_BASE   = 55;
  localparam int BALL_WIDTH_PX = 4;
  localparam int HCNT_W        = 9;
  localparam int LINE_CLOCKS   = 455;

  localparam logic [HCNT_W-1:0] HBALL_RECENTRE = 9'd256;

  typedef enum logic {
    WIN_IDLE,
    WIN_VID
  } win_state_t;

endpackage

// File: rtl/ball_video_window.sv
// Ball horizontal video window.
// Holds hball high for WIDTH_PX clocks after each start pulse.
module ball_video_window
  import pong_pkg::*;
#(
  parameter int WIDTH_PX = BALL_WIDTH_PX
) (
  input  logic clk7_159,
  input  logic _rst,
  input  logic start,
  input  logic clr,
  output logic hball
);

  localparam logic [1:0] LAST = 2'(WIDTH_PX - 1);

  win_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  always_ff @(posedge clk7_159 or negedge _rst) begin
    if (!_rst) begin
      state_q <= WIN_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WIN_IDLE: begin
        if (start) begin
          state_d = WIN_VID;
          cnt_d   = 2'd0;
        end
      end
      WIN_VID: begin
        if (start) begin
          cnt_d = 2'd0;
        end else if (cnt_q == LAST) begin
          state_d = WIN_IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = WIN_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    if (clr) begin
      state_d = WIN_IDLE;
      cnt_d   = 2'd0;
    end
  end

  assign hball = (state_q == WIN_VID);

endmodule

// File: rtl/ball_horizontal_counter.sv
// Ball horizontal position counter.
// Reload from the direction code walks the ball against the line.
module ball_horizontal_counter
  import pong_pkg::*;
#(
  parameter logic [HCNT_W-1:0] BASE = 9'(BALL_H_BASE),
  parameter int WIDTH_PX = BALL_WIDTH_PX
) (
  input  logic              clk7_159,
  input  logic              _rst,
  input  logic              aa,
  input  logic              ba,
  input  logic              recentre,
  output logic [HCNT_W-1:0] hpos,
  output logic              hball_tc,
  output logic              hball
);

  logic [HCNT_W-1:0] hpos_q, hpos_d;
  logic [HCNT_W-1:0] reload;

  assign reload   = BASE + HCNT_W'({ba, aa});
  assign hball_tc = &hpos_q;
  assign hpos     = hpos_q;

  always_comb begin
    hpos_d = hpos_q + 1'b1;
    if (recentre)
      hpos_d = HBALL_RECENTRE;
    else if (hball_tc)
      hpos_d = reload;
  end

  always_ff @(posedge clk7_159 or negedge _rst) begin
    if (!_rst)
      hpos_q <= '0;
    else
      hpos_q <= hpos_d;
  end

  // A recentre on the terminal count must not open a window.
  ball_video_window #(
    .WIDTH_PX(WIDTH_PX)
  ) u_window (
    .clk7_159(clk7_159),
    ._rst    (_rst),
    .start   (hball_tc & ~recentre),
    .clr     (recentre),
    .hball   (hball)
  );

endmodule

// File: tb/tb_ball_horizontal_counter.sv
// Self-checking bench for ball_horizontal_counter.
// Model tracks clocks-to-strobe and remaining window clocks.
`timescale 1ns/1ps
module tb_ball_horizontal_counter;

  logic       clk = 1'b0;
  logic       _rst = 1'b0;
  logic       aa = 1'b0;
  logic       ba = 1'b1;
  logic       recentre = 1'b0;
  logic [8:0] hpos;
  logic       hball_tc;
  logic       hball;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int to_tc = 511;
  int win   = 0;

  always #5 clk = ~clk;

  ball_horizontal_counter dut (
    .clk7_159(clk),
    ._rst    (_rst),
    .aa      (aa),
    .ba      (ba),
    .recentre(recentre),
    .hpos    (hpos),
    .hball_tc(hball_tc),
    .hball   (hball)
  );

  function automatic int period(input int code);
    return 512 - (55 + code);
  endfunction

  task automatic model_reset();
    to_tc = 511;
    win   = 0;
  endtask

  task automatic step();
    int code;
    bit rc;
    logic [8:0] e_pos;
    @(posedge clk);
    code = int'({ba, aa});
    rc   = recentre;
    if (rc) begin
      to_tc = 255;
      win   = 0;
    end else if (to_tc == 0) begin
      to_tc = period(code) - 1;
      win   = 4;
    end else begin
      to_tc = to_tc - 1;
      if (win > 0) win = win - 1;
    end
    cyc++;
    @(negedge clk);
    e_pos = 9'(511 - to_tc);
    tests++;
    if (hpos !== e_pos || hball_tc !== (to_tc == 0) || hball !== (win > 0)) begin
      fails++;
      $display("FAIL cycle%0d: hpos=%0d tc=%b hball=%b, want hpos=%0d tc=%b hball=%b",
               cyc, hpos, hball_tc, hball, e_pos, to_tc == 0, win > 0);
    end
  endtask

  task automatic wait_tc(output int at);
    int n = 0;
    do begin
      step();
      n++;
    end while (hball_tc !== 1'b1 && n < 600);
    tests++;
    if (hball_tc !== 1'b1) begin
      fails++;
      $display("FAIL tc_timeout: tc=%b after %0d clocks, want 1", hball_tc, n);
    end
    at = cyc;
  endtask

  task automatic check_gap(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: spacing=%0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    _rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (hpos !== 9'd0 || hball_tc !== 1'b0 || hball !== 1'b0) begin
      fails++;
      $display("FAIL reset: hpos=%0d tc=%b hball=%b, want 0 0 0", hpos, hball_tc, hball);
    end
    _rst = 1'b1;
    model_reset();
  endtask

  task automatic test_stationary();
    int t0, t1, t2;
    t0 = cyc;
    {ba, aa} = 2'b10;
    wait_tc(t1);
    check_gap("first_tc", t1 - t0, 511);
    wait_tc(t2);
    check_gap("stationary1", t2 - t1, 455);
    wait_tc(t1);
    check_gap("stationary2", t1 - t2, 455);
  endtask

  task automatic test_dir(input string name, input logic [1:0] code,
                          input int rl, input int gap);
    int t0, t1;
    {ba, aa} = code;
    t0 = cyc;
    step();
    tests++;
    if (hpos !== 9'(rl)) begin
      fails++;
      $display("FAIL %s_reload: hpos=%0d, want %0d", name, hpos, rl);
    end
    wait_tc(t1);
    check_gap(name, t1 - t0, gap);
    wait_tc(t0);
    check_gap(name, t0 - t1, gap);
  endtask

  task automatic test_mid_change();
    int t0, t1, t2, t3, n;
    {ba, aa} = 2'b10;
    wait_tc(t0);
    n = 0;
    while (hpos !== 9'd300 && n < 600) begin
      step();
      n++;
    end
    {ba, aa} = 2'b11;
    wait_tc(t1);
    check_gap("mid_change_cur", t1 - t0, 455);
    wait_tc(t2);
    check_gap("mid_change_next", t2 - t1, 454);
    {ba, aa} = 2'b01;
    wait_tc(t3);
    check_gap("toggle_at_tc", t3 - t2, 456);
  endtask

  task automatic test_recentre();
    int t0, t1;
    {ba, aa} = 2'b10;
    wait_tc(t0);
    step();
    step();
    recentre = 1'b1;
    step();
    recentre = 1'b0;
    tests++;
    if (hpos !== 9'd256 || hball !== 1'b0) begin
      fails++;
      $display("FAIL recentre_win: hpos=%0d hball=%b, want 256 0", hpos, hball);
    end
    t0 = cyc;
    wait_tc(t1);
    check_gap("recentre_gap", t1 - t0, 255);
    recentre = 1'b1;
    tests++;
    if (hball_tc !== 1'b1) begin
      fails++;
      $display("FAIL recentre_tc: tc=%b, want 1", hball_tc);
    end
    step();
    recentre = 1'b0;
    tests++;
    if (hpos !== 9'd256 || hball !== 1'b0) begin
      fails++;
      $display("FAIL recentre_at_tc: hpos=%0d hball=%b, want 256 0", hpos, hball);
    end
    step();
  endtask

  task automatic test_async_reset();
    int t0, t1;
    {ba, aa} = 2'b10;
    wait_tc(t0);
    step();
    step();
    #2 _rst = 1'b0;
    #1;
    tests++;
    if (hpos !== 9'd0 || hball_tc !== 1'b0 || hball !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: hpos=%0d tc=%b hball=%b, want 0 0 0",
               hpos, hball_tc, hball);
    end
    model_reset();
    repeat (2) @(negedge clk);
    _rst = 1'b1;
    t0 = cyc;
    wait_tc(t1);
    check_gap("post_reset_tc", t1 - t0, 511);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      {ba, aa} = 2'($urandom_range(0, 3));
      recentre = ($urandom_range(0, 99) == 0);
      step();
    end
    recentre = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stationary();
    test_dir("right", 2'b01, 56, 456);
    test_dir("left", 2'b11, 58, 454);
    test_mid_change();
    test_recentre();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
